// File: rtl/count_arb_pkg.sv
// Shared types and the round-robin pick function for the shared event counter arbiter.
package count_arb_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        FULL = 1'b1
    } state_t;

    // Widest supported requester set; rr_pick works on this fixed width.
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned MAX_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // First set bit of elig scanning ptr, ptr+1, ... modulo n_req.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   elig,
                                      input logic [MAX_IDX_W-1:0] ptr,
                                      input int unsigned          n_req);
        pick_t                p;
        int unsigned          idx;
        logic [MAX_IDX_W-1:0] idx_n;
        p = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx   = (32'(ptr) + i) % n_req;
            idx_n = idx[MAX_IDX_W-1:0];
            if ((i < n_req) && !p.valid && elig[idx_n]) begin
                p.valid = 1'b1;
                p.idx   = idx_n;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority rotate plus the rotating pointer register.
module rr_arbiter
    import count_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [N_REQ-1:0] elig,
    input  logic             advance,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [MAX_REQ-1:0]   elig_ext;
    logic [MAX_IDX_W-1:0] ptr_ext;
    pick_t                pick;

    // Winner selection and pointer update.
    always_comb begin
        elig_ext              = '0;
        elig_ext[N_REQ-1:0]   = elig;
        ptr_ext               = '0;
        ptr_ext[IDX_W-1:0]    = ptr_q;
        pick                  = rr_pick(elig_ext, ptr_ext, N_REQ);
        winner                = pick.idx[IDX_W-1:0];
        valid                 = pick.valid;

        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (advance && valid) begin
            // Next scan starts just past the winner.
            if (winner == IDX_W'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + 1'b1;
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shared_count_arbiter.sv
// Round-robin sharing of one saturating event counter among N_REQ requesters.
module shared_count_arbiter
    import count_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CNT_W = 5,
    parameter int unsigned LIMIT = 10,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             clr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [N_REQ-1:0] elig;
    logic [IDX_W-1:0] winner;
    logic             valid;
    logic             advance;

    // A requester granted this cycle sits out one edge.
    assign elig    = req & ~gnt_q;
    assign advance = (state_q == RUN) && !clr;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr_arbiter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .elig   (elig),
        .advance(advance),
        .winner (winner),
        .valid  (valid)
    );

    // Next-state: clear wins, otherwise grant and count while in RUN.
    always_comb begin
        state_d  = state_q;
        gnt_d    = '0;
        gnt_id_d = gnt_id_q;
        count_d  = count_q;
        if (clr) begin
            state_d = RUN;
            count_d = '0;
        end else if (advance && valid) begin
            gnt_d    = N_REQ'(1) << winner;
            gnt_id_d = winner;
            count_d  = count_q + 1'b1;
            // RUN implies count_q < LIMIT, so this never overshoots.
            if (count_d == CNT_W'(LIMIT)) begin
                state_d = FULL;
            end
        end
    end

    // State, grant and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            count_q  <= count_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign count  = count_q;
    assign full   = (state_q == FULL);

endmodule

// File: tb/tb_shared_count_arbiter.sv
// Directed bench for shared_count_arbiter with an expected-result queue.
module tb_shared_count_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       clr;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic [4:0] count;
    logic       full;

    shared_count_arbiter #(
        .N_REQ(4),
        .CNT_W(5),
        .LIMIT(10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .clr   (clr),
        .gnt   (gnt),
        .gnt_id(gnt_id),
        .count (count),
        .full  (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic [4:0] cnt;
        logic       full;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input logic [3:0] g, input logic [1:0] id, input logic [4:0] c,
                        input logic f);
        exp_t e;
        e.gnt  = g;
        e.id   = id;
        e.cnt  = c;
        e.full = f;
        sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: no expected entry queued", tag);
        end else begin
            e = sb.pop_front();
            cmp({tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
            cmp({tag, ".gnt_id"}, 32'(gnt_id), 32'(e.id));
            cmp({tag, ".count"}, 32'(count), 32'(e.cnt));
            cmp({tag, ".full"}, 32'(full), 32'(e.full));
        end
    endtask

    // Drive inputs, queue the expected post-edge outputs, clock, then compare.
    task automatic step(input string tag, input logic [3:0] r, input logic c,
                        input logic [3:0] g, input logic [1:0] id, input logic [4:0] cnt,
                        input logic f);
        req = r;
        clr = c;
        push(g, id, cnt, f);
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        logic [1:0] id;
        rst_n = 1'b0;
        req   = '0;
        clr   = 1'b0;
        #1;

        // Reset held with random inputs: everything stays zero.
        for (int k = 0; k < 4; k++) begin
            step("reset", 4'($urandom), 1'($urandom), 4'b0000, 2'd0, 5'd0, 1'b0);
        end

        // Single requester: grant every other edge until saturation.
        rst_n = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            step("single", 4'b0001, 1'b0, (k % 2 == 1) ? 4'b0001 : 4'b0000, 2'd0,
                 5'((k + 1) / 2), k == 19);
        end
        for (int k = 0; k < 10; k++) begin
            step("single_full", 4'b0001, 1'b0, 4'b0000, 2'd0, 5'd10, 1'b1);
        end

        // Clear while FULL beats a simultaneous request; the request wins next edge.
        step("clr_full", 4'b0100, 1'b1, 4'b0000, 2'd0, 5'd0, 1'b0);
        step("clr_next", 4'b0100, 1'b0, 4'b0100, 2'd2, 5'd1, 1'b0);
        step("clr_idle", 4'b0000, 1'b0, 4'b0000, 2'd2, 5'd1, 1'b0);

        // All requesters: rotate 0..3 on consecutive edges.
        step("pre_all", 4'b0000, 1'b1, 4'b0000, 2'd2, 5'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            id = 2'(k % 4);
            step("all", 4'b1111, 1'b0, 4'(4'b0001 << id), id, 5'(k + 1), k == 9);
        end
        for (int k = 0; k < 3; k++) begin
            step("all_full", 4'b1111, 1'b0, 4'b0000, 2'd1, 5'd10, 1'b1);
        end

        // Sparse requests 1010 from ptr 0: 1,3,1,3.
        step("pre_sparse", 4'b0000, 1'b1, 4'b0000, 2'd1, 5'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            id = (k % 2 == 1) ? 2'd3 : 2'd1;
            step("sparse", 4'b1010, 1'b0, 4'(4'b0001 << id), id, 5'(k + 1), 1'b0);
        end
        step("sparse_idle", 4'b0000, 1'b0, 4'b0000, 2'd3, 5'd4, 1'b0);

        // req[2] pulsed one cycle behind requester 0: never granted.
        step("pre_drop", 4'b0000, 1'b1, 4'b0000, 2'd3, 5'd0, 1'b0);
        step("drop_a", 4'b0101, 1'b0, 4'b0001, 2'd0, 5'd1, 1'b0);
        step("drop_b", 4'b0001, 1'b0, 4'b0000, 2'd0, 5'd1, 1'b0);
        step("drop_c", 4'b0001, 1'b0, 4'b0001, 2'd0, 5'd2, 1'b0);
        step("drop_d", 4'b0000, 1'b0, 4'b0000, 2'd0, 5'd2, 1'b0);

        // Fill to 6 (pointer ends at 2), then reset asynchronously mid-cycle.
        step("pre_async", 4'b0000, 1'b1, 4'b0000, 2'd0, 5'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            id = 2'(k % 4);
            step("fill", 4'b1111, 1'b0, 4'(4'b0001 << id), id, 5'(k + 1), 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        push(4'b0000, 2'd0, 5'd0, 1'b0);
        pop_check("async_rst");
        #2;
        rst_n = 1'b1;
        step("after_rst", 4'b1111, 1'b0, 4'b0001, 2'd0, 5'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shared_count_arbiter.md
# shared_count_arbiter

- Round-robin controller that shares one saturating event counter among `N_REQ` requesters.
- Each granted request increments the counter by exactly one. The counter stops at `LIMIT` until a synchronous clear.
- Sits between the event sources and the shared count register; it sequences all increments so that simultaneous events are never lost or merged.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `CNT_W`, 5, counter width
- `LIMIT`, 10, saturation value; must satisfy 1 <= `LIMIT` <= 2^`CNT_W`-1

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  `N_REQ`  level request per requester; one increment per grant
- `clr`  in  1  synchronous clear of counter, pointer and state
- `gnt`  out  `N_REQ`  registered one-hot grant, one-cycle pulse
- `gnt_id`  out  `$clog2(N_REQ)`  index of the current grant; holds its last value when `gnt`==0
- `count`  out  `CNT_W`  registered counter value
- `full`  out  1  high while state is FULL

## Operation
- **Reset** (`rst_n`=0, takes effect immediately, no clock needed):
  - `count`=0, `gnt`=0, `gnt_id`=0, `full`=0
  - round-robin pointer `ptr`=0, state RUN
- **States:**
  - RUN: grants are issued.
  - FULL: no grants are issued; all requests are ignored and stall.
- **Eligibility:** `elig` = `req` & ~`gnt`. A requester granted in this cycle is masked for this edge, so one requester gets at most one grant every two cycles.
- **Arbitration in RUN, when `elig`!=0:**
  - Winner w = first eligible index, scanning `ptr`, `ptr`+1, … modulo `N_REQ`.
  - At the edge: `gnt`<=onehot(w), `gnt_id`<=w, `count`<=`count`+1, `ptr`<=(w+1) mod `N_REQ`.
- **When no grant occurs** (`elig`==0, or state FULL): `gnt`<=0; `count`, `ptr` and `gnt_id` hold.
- **RUN -> FULL:** at the edge where `count` becomes `LIMIT`. `full` rises on the same edge as the final `gnt`.
- **Saturation:** `count` never exceeds `LIMIT` and never wraps.
- **`clr`=1 at an edge**, from any state:
  - `count`<=0, `gnt`<=0, `ptr`<=0, state<=RUN, `full`<=0; `gnt_id` holds.
  - `clr` takes priority over any request at that edge; that request is not granted and not counted.
- **Arithmetic:** unsigned, width `CNT_W`. The comparison against `LIMIT` uses the next-state value.
- **Requester contract:** a requester wanting k increments holds `req` until it has seen k `gnt` pulses. Dropping `req` before a grant is legal and discards that request without counting it.

## Timing
- Latency: `req` sampled high at edge n (in RUN, and winning arbitration) -> `gnt` and the updated `count` visible after edge n, together.
- Throughput: one increment per cycle, provided at least two requesters are active.
- `clr` -> `count`==0 and `full`==0 after the next edge.
- `rst_n` deassertion is synchronised externally; the first grant can occur at the first edge with `rst_n`=1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
Shared package `count_arb_pkg`:
- `state_t` enum {RUN, FULL}
- function `rr_pick`(elig, ptr), returning the winner index and a valid flag

Sub-module `rr_arbiter`:
- Combinational priority rotate plus the `ptr` register.
- Ports: `clk`, `rst_n`, `clr`, `elig`, `advance`, `winner`, `valid`.
- Parameterised by `N_REQ`.

Top level holds the FSM, the counter, the `gnt`/`gnt_id` registers and the `full` logic.

## Test plan
1. **Reset values:** hold `rst_n`=0 with random `req`/`clr` -> all outputs 0. Assert `rst_n` low between clock edges while `count`=6 -> `count`=0, `full`=0, `gnt`=0 immediately, and the next grant comes from index 0.
2. **Single requester:** `req`=4'b0001 held from the first edge after reset -> `gnt[0]` on edges 1,3,5,…,19. `count` reaches 10 and `full`=1 at edge 19; no further `gnt` over the next 10 cycles.
3. **All requesters:** `req`=4'b1111 held -> grants rotate 0,1,2,3,0,1,2,3,0,1 on consecutive edges. `full`=1 after edge 10 with `gnt_id`=1; `gnt`=0 afterwards.
4. **Sparse requests:** `req`=4'b1010 held, `ptr`=0 -> grant sequence 1,3,1,3; `count` increments every cycle.
5. **Clear:** `clr`=1 together with `req`=4'b0100 while FULL -> at that edge `count`=0, `full`=0, `gnt`=0. At the next edge `gnt`=4'b0100 and `count`=1.
6. **Dropped request:** `req[2]` pulsed for one cycle while `req[0]` has priority -> `req[2]` is never granted, and `count` reflects only the grants to requester 0.
